// File: rtl/alu_32_bit.sv
// 32-bit MIPS ALU: combinational operation select feeding a registered
// result and a 2-bit {negative, zero} status, one cycle of latency.
module alu_32_bit (
    input  logic               clk,
    input  logic               reset,
    input  logic        [3:0]  aluCode,
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] result,
    output logic        [1:0]  zero
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_LUI  = 4'b1010,
        OP_NOR  = 4'b1100
    } alu_op_t;

    logic [31:0] next_result;
    logic [1:0]  next_zero;
    logic [4:0]  shamt;

    assign shamt = b[4:0];

    always_comb begin
        next_result = '0;
        case (aluCode)
            OP_AND:  next_result = a & b;
            OP_OR:   next_result = a | b;
            OP_ADD:  next_result = a + b;
            OP_XOR:  next_result = a ^ b;
            OP_SLL:  next_result = a << shamt;
            OP_SRL:  next_result = $unsigned(a) >> shamt;
            OP_SUB:  next_result = a - b;
            OP_SLT:  next_result = {31'b0, (a < b)};
            OP_SRA:  next_result = a >>> shamt;
            OP_SLTU: next_result = {31'b0, ($unsigned(a) < $unsigned(b))};
            OP_LUI:  next_result = {b[15:0], 16'h0000};
            OP_NOR:  next_result = ~(a | b);
            default: next_result = '0;
        endcase
    end

    // A zero result has bit 31 clear, so the status can never be 2'b11.
    assign next_zero = {next_result[31], (next_result == '0)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 2'b01;
        end else begin
            result <= next_result;
            zero   <= next_zero;
        end
    end

endmodule

// File: tb/tb_alu_32_bit.sv
// Self-checking bench for alu_32_bit: directed literal cases plus a random
// stream compared every cycle against an arithmetic reference model.
module tb_alu_32_bit;

    logic               clk;
    logic               reset;
    logic        [3:0]  aluCode;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] result;
    logic        [1:0]  zero;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    logic [31:0] exp_result = '0;
    logic [1:0]  exp_zero   = 2'b01;

    alu_32_bit dut (
        .clk     (clk),
        .reset   (reset),
        .aluCode (aluCode),
        .a       (a),
        .b       (b),
        .result  (result),
        .zero    (zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: operations as plain arithmetic (shifts as scaling by 2^n).
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p2;
        logic [63:0] wide;
        p2 = 32'd1 << y[4:0];
        case (c)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd3:  return x ^ y;
            4'd4:  begin wide = {32'd0, x} * {32'd0, p2}; return wide[31:0]; end
            4'd5:  return x / p2;
            4'd6:  return x + (~y + 32'd1);
            4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8:  return x[31] ? ~((~x) / p2) : (x / p2);
            4'd9:  return (x < y) ? 32'd1 : 32'd0;
            4'd10: return y * 32'd65536;
            4'd12: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] status(input logic [31:0] r);
        return {r[31], (r == 32'd0)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_result <= '0;
            exp_zero   <= 2'b01;
        end else begin
            exp_result <= model(aluCode, a, b);
            exp_zero   <= status(model(aluCode, a, b));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (result !== exp_result || zero !== exp_zero) begin
                failures++;
                $display("FAIL stream t=%0t code=%b a=%h b=%h got=%h/%b want=%h/%b",
                         $time, aluCode, a, b, result, zero, exp_result, exp_zero);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got_r, input logic [1:0] got_z,
                         input logic [31:0] want_r, input logic [1:0] want_z);
        checks++;
        if (got_r !== want_r || got_z !== want_z) begin
            failures++;
            $display("FAIL %s got=%h/%b want=%h/%b", name, got_r, got_z, want_r, want_z);
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want_r, input logic [1:0] want_z);
        @(negedge clk);
        aluCode = c; a = x; b = y;
        check({name, "_model"}, model(c, x, y), status(model(c, x, y)), want_r, want_z);
        @(posedge clk);
        #1;
        check(name, result, zero, want_r, want_z);
    endtask

    initial begin
        reset = 1; aluCode = 4'd2; a = 32'd123; b = 32'd456;
        #1;
        check("reset_async_init", result, zero, 32'd0, 2'b01);
        repeat (2) @(negedge clk);
        reset = 0;
        cmp_en = 1;

        do_op("add_5_9",   4'b0010, 32'd5, 32'd9, 32'd14, 2'b00);
        do_op("add_16_32", 4'b0010, 32'd16, 32'd32, 32'd48, 2'b00);
        do_op("add_m7_9",  4'b0010, -32'sd7, 32'd9, 32'd2, 2'b00);
        do_op("add_ovf",   4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 2'b10);
        do_op("sub_zero",  4'b0110, 32'd9, 32'd9, 32'd0, 2'b01);
        do_op("sub_neg",   4'b0110, -32'sd7, 32'd9, 32'hFFFFFFF0, 2'b10);
        do_op("slt",       4'b0111, -32'sd7, 32'd9, 32'd1, 2'b00);
        do_op("sltu",      4'b1001, -32'sd7, 32'd9, 32'd0, 2'b01);
        do_op("sll",       4'b0100, 32'h80000010, 32'd4, 32'h00000100, 2'b00);
        do_op("srl",       4'b0101, 32'h80000010, 32'd4, 32'h08000001, 2'b00);
        do_op("sra",       4'b1000, 32'h80000010, 32'd4, 32'hF8000001, 2'b10);
        do_op("sll_b4_0",  4'b0100, 32'd1, 32'h24, 32'd16, 2'b00);
        do_op("nor_0_0",   4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 2'b10);
        do_op("lui",       4'b1010, 32'd0, 32'h1234, 32'h12340000, 2'b00);
        do_op("unused_f",  4'b1111, 32'd5, 32'd3, 32'd0, 2'b01);
        do_op("xor",       4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 2'b00);

        // Reset between two ADDs: the second ADD is in flight and must be lost.
        do_op("add_pre_rst", 4'b0010, 32'd1, 32'd2, 32'd3, 2'b00);
        @(negedge clk);
        aluCode = 4'b0010; a = 32'd100; b = 32'd200;
        #2;
        reset = 1;
        #1;
        check("reset_async_mid", result, zero, 32'd0, 2'b01);
        @(posedge clk);
        #1;
        check("reset_discard", result, zero, 32'd0, 2'b01);
        @(negedge clk);
        reset = 0;
        do_op("add_post_rst", 4'b0010, 32'd7, 32'd8, 32'd15, 2'b00);

        // Random stream with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            aluCode = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, 20));
                1: a = 32'h80000000 | 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        cmp_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
